// File: rtl/matrix_store_pkg.sv
// Shared constants for matrix_store: FSM encoding, GF(3) symbol format, CLOG2 helper.
// MATRIX_STORE_SYMCHK_EN (see matrix_store.sv) uses has_illegal_sym() from here.
`ifndef MATRIX_STORE_CLOG2
`define MATRIX_STORE_CLOG2(x) $clog2(x)
`endif

package matrix_store_pkg;

  localparam int SYM_W = 2;
  localparam logic [SYM_W-1:0] SYM_ILLEGAL = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DUMP = 2'd3;

  // Word is zero-extended to 32 bits by the caller; nsym symbols are inspected.
  function automatic logic has_illegal_sym(input logic [31:0] word, input int nsym);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 32 / SYM_W; i++)
      if (i < nsym && word[i*SYM_W +: SYM_W] == SYM_ILLEGAL) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/matrix_store_ram.sv
// Single-clock storage: one write port, one read port, read-first, registered output.
module matrix_store_ram #(
  parameter int D  = 40,
  parameter int AW = 6,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [D];
  logic [DW-1:0] rdata_q;

  // Contents survive reset; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/matrix_store.sv
// Matrix buffer between host and systemizer: host load, systemizer RUN access, host readback.
// Define MATRIX_STORE_SYMCHK_EN to flag stored words containing the illegal GF(3) symbol.
module matrix_store
  import matrix_store_pkg::*;
#(
  parameter int L  = 8,
  parameter int K  = 10,
  parameter int D  = L * K / 2,
  parameter int AW = `MATRIX_STORE_CLOG2(D),
  parameter int DW = 2 * `MATRIX_STORE_CLOG2(3)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          host_valid,
  input  logic [DW-1:0] host_data,
  output logic          host_ready,
  output logic          start,
  input  logic          done,
  input  logic          success,
  input  logic          fail,
  input  logic          sys_rd_en,
  input  logic [AW-1:0] sys_rd_addr,
  output logic [DW-1:0] sys_rd_data,
  input  logic          sys_wr_en,
  input  logic [AW-1:0] sys_wr_addr,
  input  logic [DW-1:0] sys_wr_data,
  output logic          dump_valid,
  output logic [DW-1:0] dump_data,
  input  logic          dump_ready,
  output logic          busy,
  output logic          result_ok,
  output logic          err
);

  localparam logic [AW-1:0] LAST  = AW'(D - 1);
  localparam logic [AW:0]   DEPTH = (AW + 1)'(D);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          start_q, start_d;
  logic          dump_valid_q, dump_valid_d;
  logic          result_ok_q, result_ok_d;
  logic          err_q, err_d;
  logic          rd_oor_q, rd_oor_d;

  logic          run, load_acc, dump_acc, fetch, rd_ok, wr_ok;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  always_comb begin
    run       = (state_q == ST_RUN);
    load_acc  = (state_q == ST_LOAD) && host_valid;
    dump_acc  = (state_q == ST_DUMP) && dump_valid_q && dump_ready;
    fetch     = (state_q == ST_DUMP) && !dump_valid_q;
    rd_ok     = {1'b0, sys_rd_addr} < DEPTH;
    wr_ok     = {1'b0, sys_wr_addr} < DEPTH;
    // rst gates the write so an aborted load leaves no trace of the in-flight word.
    ram_we    = !rst && (load_acc || (run && sys_wr_en && wr_ok));
    ram_waddr = (state_q == ST_LOAD) ? wptr_q : sys_wr_addr;
    ram_wdata = (state_q == ST_LOAD) ? host_data : sys_wr_data;
    ram_re    = fetch || (run && sys_rd_en && rd_ok);
    ram_raddr = (state_q == ST_DUMP) ? rptr_q : sys_rd_addr;
  end

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    start_d      = 1'b0;
    dump_valid_d = dump_valid_q;
    result_ok_d  = result_ok_q;
    err_d        = err_q;
    rd_oor_d     = rd_oor_q;
    case (state_q)
      ST_IDLE: if (load_start) begin
        state_d     = ST_LOAD;
        wptr_d      = '0;
        result_ok_d = 1'b0;
        err_d       = 1'b0;
      end
      ST_LOAD: if (load_acc) begin
        if (wptr_q == LAST) begin
          state_d = ST_RUN;
          start_d = 1'b1;
        end else begin
          wptr_d = wptr_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (sys_rd_en) rd_oor_d = !rd_ok;
        if ((sys_rd_en && !rd_ok) || (sys_wr_en && !wr_ok)) err_d = 1'b1;
        if (done) begin
          result_ok_d = success && !fail;
          rptr_d      = '0;
          state_d     = ST_DUMP;
        end
      end
      ST_DUMP: begin
        if (fetch) begin
          dump_valid_d = 1'b1;
          rd_oor_d     = 1'b0;
        end else if (dump_acc) begin
          dump_valid_d = 1'b0;
          if (rptr_q == LAST) state_d = ST_IDLE;
          else                rptr_d  = rptr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef MATRIX_STORE_SYMCHK_EN
    if (ram_we && has_illegal_sym(32'(ram_wdata), DW / SYM_W)) err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      start_q      <= 1'b0;
      dump_valid_q <= 1'b0;
      result_ok_q  <= 1'b0;
      err_q        <= 1'b0;
      rd_oor_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      start_q      <= start_d;
      dump_valid_q <= dump_valid_d;
      result_ok_q  <= result_ok_d;
      err_q        <= err_d;
      rd_oor_q     <= rd_oor_d;
    end
  end

  matrix_store_ram #(.D(D), .AW(AW), .DW(DW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // The shared read register serves both the systemizer and the dump path.
  assign sys_rd_data = rd_oor_q ? '0 : ram_rdata;
  assign dump_data   = ram_rdata;
  assign dump_valid  = dump_valid_q;
  assign host_ready  = (state_q == ST_LOAD);
  assign busy        = (state_q != ST_IDLE);
  assign start       = start_q;
  assign result_ok   = result_ok_q;
  assign err         = err_q;

endmodule
